cpc_slot_arbiter: RTL and testbench



---
 rtl/cpc_slot_arbiter_if.sv | 26 ++
 rtl/cpc_slot_arbiter.sv | 62 ++++++
 tb/tb_cpc_slot_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpc_slot_arbiter_if.sv
// cpc_slot_arbiter_if: slot-wheel control, CPU/DMA handshake and video fetch signals.
interface cpc_slot_arbiter_if #(
    parameter int SLOTS   = 4,
    parameter int VADDR_W = 15
);
    localparam int SW = $clog2(SLOTS);
    logic               ce;
    logic               resync;
    logic               no_wait;
    logic               cpu_req;
    logic               cpu_wait_n;
    logic               dma_req;
    logic               dma_gnt;
    logic [VADDR_W-1:0] vid_addr;
    logic [VADDR_W-1:0] vram_addr;
    logic               vid_stb;
    logic [SW-1:0]      slot;
    modport master (
        output ce, resync, no_wait, cpu_req, dma_req, vid_addr,
        input  cpu_wait_n, dma_gnt, vram_addr, vid_stb, slot
    );
    modport slave (
        input  ce, resync, no_wait, cpu_req, dma_req, vid_addr,
        output cpu_wait_n, dma_gnt, vram_addr, vid_stb, slot
    );
endinterface

// File: rtl/cpc_slot_arbiter.sv
// cpc_slot_arbiter: N-slot memory wheel sharing RAM between CPU, DMA and video fetch.
module cpc_slot_arbiter #(
    parameter int SLOTS     = 4,
    parameter int CPU_SLOT  = 0,
    parameter int VID_SLOT  = 2,
    parameter int VADDR_W   = 15,
    parameter int MAX_STEAL = 2
) (
    input logic              clk,
    input logic              reset_n,
    cpc_slot_arbiter_if.slave bus
);
    localparam int SW = $clog2(SLOTS);
    localparam int CW = MAX_STEAL > 0 ? $clog2(MAX_STEAL + 1) : 1;

    logic [SW-1:0]      slot_q, slot_d, nslot;
    logic               wait_q, wait_d, gnt_q, gnt_d, stb_q, stb_d;
    logic [VADDR_W-1:0] vram_q, vram_d;
    logic [CW-1:0]      steal_q, steal_d;
    logic               at_cpu, at_vid, dma_win;

    always_comb begin
        nslot   = bus.resync ? '0 : slot_q + 1'b1;
        at_cpu  = nslot == SW'(CPU_SLOT);
        at_vid  = nslot == SW'(VID_SLOT);
        // DMA may only pre-empt a waiting CPU a bounded number of times in a row
        dma_win = bus.dma_req & at_cpu &
                  (~bus.cpu_req | (~bus.no_wait & (steal_q < CW'(MAX_STEAL))));
        slot_d  = bus.ce ? nslot : slot_q;
        wait_d  = bus.ce ? (bus.no_wait | ~bus.cpu_req | (at_cpu & ~dma_win)) : wait_q;
        gnt_d   = bus.ce & dma_win;
        stb_d   = bus.ce & at_vid;
        vram_d  = (bus.ce & at_vid) ? bus.vid_addr : vram_q;
        steal_d = steal_q;
        if (bus.ce & at_cpu & bus.cpu_req)
            steal_d = ~dma_win ? '0 : (steal_q == CW'(MAX_STEAL)) ? steal_q : steal_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= '0;
            wait_q  <= 1'b1;
            gnt_q   <= 1'b0;
            stb_q   <= 1'b0;
            vram_q  <= '0;
            steal_q <= '0;
        end else begin
            slot_q  <= slot_d;
            wait_q  <= wait_d;
            gnt_q   <= gnt_d;
            stb_q   <= stb_d;
            vram_q  <= vram_d;
            steal_q <= steal_d;
        end
    end

    assign bus.slot       = slot_q;
    assign bus.cpu_wait_n = wait_q;
    assign bus.dma_gnt    = gnt_q;
    assign bus.vid_stb    = stb_q;
    assign bus.vram_addr  = vram_q;
endmodule

// File: tb/tb_cpc_slot_arbiter.sv
// tb_cpc_slot_arbiter: directed checks of the slot wheel, WAIT, DMA stealing and video strobe.
module tb_cpc_slot_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   es;
    logic [14:0] va;

    always #5 clk = ~clk;

    cpc_slot_arbiter_if #(.SLOTS(4), .VADDR_W(15)) a ();
    cpc_slot_arbiter_if #(.SLOTS(4), .VADDR_W(15)) b ();

    cpc_slot_arbiter #(.MAX_STEAL(2)) dut0 (.clk(clk), .reset_n(reset_n), .bus(a.slave));
    cpc_slot_arbiter #(.MAX_STEAL(0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b.slave));

    assign b.ce       = a.ce;
    assign b.resync   = a.resync;
    assign b.no_wait  = a.no_wait;
    assign b.cpu_req  = a.cpu_req;
    assign b.dma_req  = a.dma_req;
    assign b.vid_addr = a.vid_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one ce strobe; outputs sampled on the following falling edge
    task automatic tick();
        @(negedge clk);
        a.ce = 1'b1;
        @(negedge clk);
        a.ce = 1'b0;
        es = (es + 1) % 4;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    initial begin
        a.ce = 0; a.resync = 0; a.no_wait = 0; a.cpu_req = 0; a.dma_req = 0; a.vid_addr = '0;
        es = 0;
        #12;
        chk("rst_slot", a.slot, 0);
        chk("rst_wait", a.cpu_wait_n, 1);
        chk("rst_gnt", a.dma_gnt, 0);
        chk("rst_stb", a.vid_stb, 0);
        chk("rst_vram", a.vram_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        chk("ce_off_hold", a.slot, 0);

        for (int i = 0; i < 8; i++) begin
            a.vid_addr = 15'h100 + 15'(i);
            tick();
            chk("wheel_slot", a.slot, es);
            chk("wheel_slot_b", b.slot, es);
            chk("wheel_stb", a.vid_stb, es == 2);
            chk("wheel_wait", a.cpu_wait_n, 1);
            if (es == 2) chk("wheel_vram", a.vram_addr, 32'h100 + i);
            idle();
            chk("stb_clear", a.vid_stb, 0);
        end

        tick();
        chk("pre_wait_slot", a.slot, 1);
        a.cpu_req = 1;
        tick(); chk("wait_s2", a.cpu_wait_n, 0);
        tick(); chk("wait_s3", a.cpu_wait_n, 0);
        tick(); chk("wait_s0", a.cpu_wait_n, 1);
        tick(); chk("wait_s1", a.cpu_wait_n, 0);
        a.cpu_req = 0;
        tick(); chk("wait_drop", a.cpu_wait_n, 1);

        a.cpu_req = 1; a.dma_req = 1;
        tick(); chk("steal_s3_wait", a.cpu_wait_n, 0);
        for (int r = 0; r < 4; r++) begin
            tick();
            chk("steal_slot0", a.slot, 0);
            chk("steal_gnt", a.dma_gnt, r != 2);
            chk("steal_wait", a.cpu_wait_n, r == 2);
            chk("nosteal_gnt", b.dma_gnt, 0);
            chk("nosteal_wait", b.cpu_wait_n, 1);
            idle();
            chk("gnt_clear", a.dma_gnt, 0);
            for (int s = 0; s < 3; s++) begin
                tick();
                chk("steal_mid_gnt", a.dma_gnt, 0);
                chk("steal_mid_wait", a.cpu_wait_n, 0);
            end
        end

        a.cpu_req = 0;
        tick();
        chk("idle_cpu_gnt_a", a.dma_gnt, 1);
        chk("idle_cpu_gnt_b", b.dma_gnt, 1);
        chk("idle_cpu_gnt_stb", a.vid_stb, 0);

        a.no_wait = 1; a.cpu_req = 1;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("turbo_wait", a.cpu_wait_n, 1);
            chk("turbo_gnt", a.dma_gnt, 0);
        end
        a.cpu_req = 0;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("turbo_drop_gnt", a.dma_gnt, es == 0);
        end
        a.no_wait = 0;

        a.cpu_req = 0; a.dma_req = 1;
        tick(); tick();
        chk("pre_resync_slot", a.slot, 2);
        a.resync = 1;
        tick();
        es = 0;
        a.resync = 0;
        chk("resync_slot", a.slot, 0);
        chk("resync_gnt", a.dma_gnt, 1);
        a.dma_req = 0; a.cpu_req = 1; va = 15'h5a5a; a.vid_addr = va;
        tick(); tick(); tick();
        chk("pre_rst_slot", a.slot, 3);
        chk("pre_rst_vram", a.vram_addr, 32'h5a5a);
        chk("pre_rst_wait", a.cpu_wait_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_slot", a.slot, 0);
        chk("async_wait", a.cpu_wait_n, 1);
        chk("async_vram", a.vram_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        a.cpu_req = 0;
        es = 0;
        tick();
        chk("post_rst_slot", a.slot, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
